// File: rtl/regfile_param.sv
// regfile_param: parameterised two-read / one-write register file with a
// sequential whole-file clear.
//
// Parameters
//   DATA_W   register width in bits (1..64)
//   ADDR_W   address width; DEPTH = 2**ADDR_W registers
//   ZERO_REG 1: register 0 is hardwired to zero and ignores writes
//   BYPASS   1: an accepted write is forwarded to matching read ports
//            in the same cycle
//
// Ports
//   CLK             clock, all state changes on the rising edge
//   RST_N           synchronous active-low reset
//   WE              write request, sampled at the rising edge
//   WrAdd, WrData   write address / data
//   CLR             start a sequential clear of the whole file
//   RdAddA, RdAddB  read addresses
//   RdDataA/B       combinational read data
//   EN              one-hot image of the write done at the last edge
//   BUSY            high while the clear sequence runs
//   dbg_state       current FSM state (0 = IDLE, 1 = CLEAR)
//
// Handshake: WE has no ready return. BUSY acts as not-ready: a write
// presented while BUSY=1, while CLR=1, or to register 0 with ZERO_REG=1
// is dropped (no array change, EN=0, no bypass). Any other write with
// WE=1 is accepted at the edge.
module regfile_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    WE,
    input  logic [ADDR_W-1:0]       WrAdd,
    input  logic [DATA_W-1:0]       WrData,
    input  logic                    CLR,
    input  logic [ADDR_W-1:0]       RdAddA,
    input  logic [ADDR_W-1:0]       RdAddB,
    output logic [DATA_W-1:0]       RdDataA,
    output logic [DATA_W-1:0]       RdDataB,
    output logic [(1<<ADDR_W)-1:0]  EN,
    output logic                    BUSY,
    output logic                    dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DEPTH-1:0]  EN_ONE   = DEPTH'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic                wr_acc;
    logic                clr_ent;
    logic [DATA_W-1:0]   mem [DEPTH];

    // State and clear pointer
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next state, write acceptance and clear strobe
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wr_acc    = 1'b0;
        clr_ent   = 1'b0;
        case (state)
            IDLE: begin
                // CLR has priority over a simultaneous write
                if (CLR) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end else if (WE && !((ZERO_REG != 0) && (WrAdd == '0))) begin
                    wr_acc = 1'b1;
                end
            end
            CLEAR: begin
                // CLR and WE are ignored here; the sequence always runs
                // exactly DEPTH steps. ptr wraps naturally at ADDR_W bits.
                clr_ent = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (ptr == PTR_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Storage array; reset zeroes every entry in the same edge
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[WrAdd] <= WrData;
        end else if (clr_ent) begin
            mem[ptr] <= '0;
        end
    end

    // One-hot write image, cleared by any edge without an accepted write
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            EN <= '0;
        end else if (wr_acc) begin
            EN <= EN_ONE << WrAdd;
        end else begin
            EN <= '0;
        end
    end

    // Read port A: array, then optional bypass, then hardwired zero
    always_comb begin
        RdDataA = mem[RdAddA];
        if ((BYPASS != 0) && wr_acc && (RdAddA == WrAdd)) begin
            RdDataA = WrData;
        end
        if ((ZERO_REG != 0) && (RdAddA == '0)) begin
            RdDataA = '0;
        end
    end

    // Read port B: same structure as port A
    always_comb begin
        RdDataB = mem[RdAddB];
        if ((BYPASS != 0) && wr_acc && (RdAddB == WrAdd)) begin
            RdDataB = WrData;
        end
        if ((ZERO_REG != 0) && (RdAddB == '0)) begin
            RdDataB = '0;
        end
    end

    assign BUSY      = (state == CLEAR);
    assign dbg_state = state;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  wr_add;
    logic [7:0]  wr_data;
    logic        clr;
    logic [3:0]  rd_add_a;
    logic [3:0]  rd_add_b;

    logic [7:0]  rd_a, rd_b, rd_a_nb, rd_b_nb, rd_a_z, rd_b_z;
    logic [15:0] en, en_nb, en_z;
    logic        busy, busy_nb, busy_z;
    logic        st, st_nb, st_z;

    int checks = 0;
    int errors = 0;

    // default configuration
    regfile_param #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut (
        .CLK(clk), .RST_N(rst_n), .WE(we), .WrAdd(wr_add), .WrData(wr_data),
        .CLR(clr), .RdAddA(rd_add_a), .RdAddB(rd_add_b),
        .RdDataA(rd_a), .RdDataB(rd_b), .EN(en), .BUSY(busy), .dbg_state(st)
    );

    // no bypass
    regfile_param #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .CLK(clk), .RST_N(rst_n), .WE(we), .WrAdd(wr_add), .WrData(wr_data),
        .CLR(clr), .RdAddA(rd_add_a), .RdAddB(rd_add_b),
        .RdDataA(rd_a_nb), .RdDataB(rd_b_nb), .EN(en_nb), .BUSY(busy_nb),
        .dbg_state(st_nb)
    );

    // hardwired register 0
    regfile_param #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .CLK(clk), .RST_N(rst_n), .WE(we), .WrAdd(wr_add), .WrData(wr_data),
        .CLR(clr), .RdAddA(rd_add_a), .RdAddB(rd_add_b),
        .RdDataA(rd_a_z), .RdDataB(rd_b_z), .EN(en_z), .BUSY(busy_z),
        .dbg_state(st_z)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b1; clr = 1'b1;
        wr_add = 4'd3; wr_data = 8'h55; rd_add_a = 4'd0; rd_add_b = 4'd0;
        step();
        step();
        rst_n = 1'b1; we = 1'b0; clr = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (en !== 16'h0000) begin errors++; $display("FAIL reset_en got %h exp 0000", en); end
        checks++;
        if (st !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", st); end
        for (int i = 0; i < 16; i++) begin
            rd_add_a = 4'(i); rd_add_b = 4'(15 - i);
            #1;
            checks++;
            if (rd_a !== 8'h00) begin errors++; $display("FAIL reset_rd_a[%0d] got %h exp 00", i, rd_a); end
            checks++;
            if (rd_b !== 8'h00) begin errors++; $display("FAIL reset_rd_b[%0d] got %h exp 00", 15 - i, rd_b); end
        end
        step();
    endtask

    task automatic test_write_read();
        we = 1'b1; wr_add = 4'd3; wr_data = 8'hA5;
        step();
        we = 1'b0; rd_add_a = 4'd3;
        #1;
        checks++;
        if (en !== 16'h0008) begin errors++; $display("FAIL wr_en got %h exp 0008", en); end
        checks++;
        if (rd_a !== 8'hA5) begin errors++; $display("FAIL wr_rd_a got %h exp a5", rd_a); end
        step();
        checks++;
        if (en !== 16'h0000) begin errors++; $display("FAIL wr_en_drop got %h exp 0000", en); end
        checks++;
        if (rd_a !== 8'hA5) begin errors++; $display("FAIL wr_rd_a_hold got %h exp a5", rd_a); end
    endtask

    task automatic test_bypass();
        we = 1'b1; wr_add = 4'd7; wr_data = 8'h3C; rd_add_b = 4'd7;
        #1;
        checks++;
        if (rd_b !== 8'h3C) begin errors++; $display("FAIL byp_rd_b got %h exp 3c", rd_b); end
        checks++;
        if (rd_b_nb !== 8'h00) begin errors++; $display("FAIL nobyp_rd_b got %h exp 00", rd_b_nb); end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rd_b_nb !== 8'h3C) begin errors++; $display("FAIL nobyp_after got %h exp 3c", rd_b_nb); end
        checks++;
        if (en !== 16'h0080) begin errors++; $display("FAIL byp_en got %h exp 0080", en); end
        step();
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wr_add = 4'd0; wr_data = 8'hFF; rd_add_a = 4'd0;
        #1;
        checks++;
        if (rd_a_z !== 8'h00) begin errors++; $display("FAIL z_byp0 got %h exp 00", rd_a_z); end
        checks++;
        if (rd_a !== 8'hFF) begin errors++; $display("FAIL nz_byp0 got %h exp ff", rd_a); end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (en_z !== 16'h0000) begin errors++; $display("FAIL z_en0 got %h exp 0000", en_z); end
        checks++;
        if (rd_a_z !== 8'h00) begin errors++; $display("FAIL z_rd0 got %h exp 00", rd_a_z); end
        checks++;
        if (en !== 16'h0001) begin errors++; $display("FAIL nz_en0 got %h exp 0001", en); end
        checks++;
        if (rd_a !== 8'hFF) begin errors++; $display("FAIL nz_rd0 got %h exp ff", rd_a); end
        we = 1'b1; wr_add = 4'd1; wr_data = 8'h5A; rd_add_a = 4'd1;
        #1;
        checks++;
        if (rd_a_z !== 8'h5A) begin errors++; $display("FAIL z_byp1 got %h exp 5a", rd_a_z); end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (en_z !== 16'h0002) begin errors++; $display("FAIL z_en1 got %h exp 0002", en_z); end
        checks++;
        if (rd_a_z !== 8'h5A) begin errors++; $display("FAIL z_rd1 got %h exp 5a", rd_a_z); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; wr_add = 4'(10 + i); wr_data = vals[i];
            step();
            checks++;
            if (en !== (16'h0001 << (10 + i))) begin
                errors++; $display("FAIL b2b_en[%0d] got %h exp %h", i, en, 16'h0001 << (10 + i));
            end
        end
        we = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            rd_add_a = 4'(10 + i);
            #1;
            checks++;
            if (rd_a !== vals[i]) begin errors++; $display("FAIL b2b_rd[%0d] got %h exp %h", i, rd_a, vals[i]); end
        end
        step();
    endtask

    task automatic test_clear();
        int cnt;
        int k;
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; wr_add = 4'(i); wr_data = 8'hC0 + 8'(i);
            step();
        end
        we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_add_a = 4'(i);
            #1;
            checks++;
            if (rd_a !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL fill_rd[%0d] got %h exp %h", i, rd_a, 8'hC0 + 8'(i)); end
        end
        step();
        clr = 1'b1;
        step();
        // during the clear: keep WE high toward address 2 and re-pulse CLR once
        clr = 1'b0; we = 1'b1; wr_add = 4'd2; wr_data = 8'h77; rd_add_b = 4'd2;
        cnt = 0;
        k = 0;
        while (busy && k < 40) begin
            clr = (k == 5);
            rd_add_a = 4'(k);
            #1;
            checks++;
            if (en !== 16'h0000) begin errors++; $display("FAIL clr_en[%0d] got %h exp 0000", k, en); end
            if (k < 16) begin
                checks++;
                if (rd_a !== 8'hC0 + 8'(k)) begin errors++; $display("FAIL clr_pending[%0d] got %h exp %h", k, rd_a, 8'hC0 + 8'(k)); end
            end
            checks++;
            if (rd_b !== ((k >= 3) ? 8'h00 : 8'hC2)) begin
                errors++; $display("FAIL clr_rd2[%0d] got %h exp %h", k, rd_b, (k >= 3) ? 8'h00 : 8'hC2);
            end
            cnt++;
            k++;
            @(posedge clk);
            #1;
        end
        we = 1'b0; clr = 1'b0;
        #1;
        checks++;
        if (cnt !== 16) begin errors++; $display("FAIL busy_cycles got %0d exp 16", cnt); end
        checks++;
        if (en !== 16'h0000) begin errors++; $display("FAIL clr_done_en got %h exp 0000", en); end
        for (int i = 0; i < 16; i++) begin
            rd_add_a = 4'(i);
            #1;
            checks++;
            if (rd_a !== 8'h00) begin errors++; $display("FAIL cleared_rd[%0d] got %h exp 00", i, rd_a); end
        end
        step();
    endtask

    task automatic test_clr_we();
        int k;
        we = 1'b1; wr_add = 4'd5; wr_data = 8'h99;
        step();
        clr = 1'b1; we = 1'b1; wr_add = 4'd5; wr_data = 8'h11; rd_add_a = 4'd5;
        #1;
        checks++;
        if (rd_a !== 8'h99) begin errors++; $display("FAIL clrwe_nobyp got %h exp 99", rd_a); end
        step();
        clr = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL clrwe_busy got %b exp 1", busy); end
        k = 0;
        while (busy && k < 40) begin
            checks++;
            if (en === 16'h0020) begin errors++; $display("FAIL clrwe_en[%0d] got %h exp 0000", k, en); end
            k++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (k !== 16) begin errors++; $display("FAIL clrwe_cycles got %0d exp 16", k); end
        rd_add_a = 4'd5;
        #1;
        checks++;
        if (rd_a !== 8'h00) begin errors++; $display("FAIL clrwe_rd5 got %h exp 00", rd_a); end
        step();
    endtask

    task automatic test_reset_mid_clear();
        we = 1'b1; wr_add = 4'd9; wr_data = 8'h42;
        step();
        wr_add = 4'd15; wr_data = 8'hEE;
        step();
        we = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (6) step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midclr_busy got %b exp 1", busy); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++;
        if (st !== 1'b0) begin errors++; $display("FAIL midrst_state got %b exp 0", st); end
        for (int i = 0; i < 16; i++) begin
            rd_add_a = 4'(i);
            #1;
            checks++;
            if (rd_a !== 8'h00) begin errors++; $display("FAIL midrst_rd[%0d] got %h exp 00", i, rd_a); end
        end
        step();
        we = 1'b1; wr_add = 4'd4; wr_data = 8'h3D;
        step();
        we = 1'b0; rd_add_a = 4'd4;
        #1;
        checks++;
        if (en !== 16'h0010) begin errors++; $display("FAIL postrst_en got %h exp 0010", en); end
        checks++;
        if (rd_a !== 8'h3D) begin errors++; $display("FAIL postrst_rd got %h exp 3d", rd_a); end
        step();
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; clr = 1'b0;
        wr_add = '0; wr_data = '0; rd_add_a = '0; rd_add_b = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_back_to_back();
        test_clear();
        test_clr_we();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
